// File: rtl/apu_pkg.sv
// Shared APU constants: length-counter duration table and default channel indices.
package apu_pkg;

    localparam int LC_IDX_W  = 5;

    localparam int CH_PULSE1 = 0;
    localparam int CH_PULSE2 = 1;
    localparam int CH_TRI    = 2;
    localparam int CH_NOISE  = 3;

    localparam logic [7:0] LC_TABLE [0:31] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

endpackage

// File: rtl/apu_lc_table.sv
// Combinational length-counter duration ROM, one instance shared by the whole bank.
module apu_lc_table
    import apu_pkg::*;
(
    input  logic [LC_IDX_W-1:0] iIdx,
    output logic [7:0]          oDuration
);

    assign oDuration = LC_TABLE[iIdx];

endmodule

// File: rtl/apu_length_counter_bank.sv
// Bank of NES-style length counters with shared duration ROM and $4015 status image.
// Optional sticky expiry flags and IRQ output when APU_LC_EXPIRY_IRQ_EN is defined.
module apu_length_counter_bank
    import apu_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int CH_W   = 2
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iTick,
    input  logic                iLoadValid,
    input  logic [CH_W-1:0]     iLoadCh,
    input  logic [LC_IDX_W-1:0] iLoadIdx,
    input  logic [NUM_CH-1:0]   iEnable,
    input  logic [NUM_CH-1:0]   iHalt,
`ifdef APU_LC_EXPIRY_IRQ_EN
    output logic [NUM_CH-1:0]   oExpired,
    output logic                oIrq,
`endif
    output logic [NUM_CH-1:0]   oActive,
    output logic [NUM_CH-1:0]   oStatus
);

    logic [7:0]                  loadDuration;
    logic [NUM_CH-1:0][CNT_W-1:0] count;

    apu_lc_table uTable (
        .iIdx      (iLoadIdx),
        .oDuration (loadDuration)
    );

    for (genvar n = 0; n < NUM_CH; n++) begin : gCh
        logic loadHit;
        logic tickDec;

        // Out-of-range channel selects match no generate index and fall through.
        assign loadHit = iLoadValid && (iLoadCh == CH_W'(n));
        assign tickDec = iTick && !iHalt[n] && (count[n] != '0) && !loadHit;

        always_ff @(posedge iClk or posedge iReset) begin
            if (iReset) begin
                count[n] <= '0;
            end else if (!iEnable[n]) begin
                count[n] <= '0;
            end else if (loadHit) begin
                count[n] <= CNT_W'(loadDuration);
            end else if (tickDec) begin
                count[n] <= count[n] - CNT_W'(1);
            end
        end

        assign oActive[n] = (count[n] != '0);

`ifdef APU_LC_EXPIRY_IRQ_EN
        // Clear (load/disable) takes precedence over a same-edge expiry.
        always_ff @(posedge iClk or posedge iReset) begin
            if (iReset) begin
                oExpired[n] <= 1'b0;
            end else if (!iEnable[n] || loadHit) begin
                oExpired[n] <= 1'b0;
            end else if (tickDec && (count[n] == CNT_W'(1))) begin
                oExpired[n] <= 1'b1;
            end
        end
`endif
    end

`ifdef APU_LC_EXPIRY_IRQ_EN
    assign oIrq = |oExpired;
`endif

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            oStatus <= '0;
        end else begin
            oStatus <= oActive;
        end
    end

endmodule
